// File: rtl/usb_pkg.sv
// Shared USB host definitions: packet IDs, endpoint numbers, OUT FSM states.
// No ports; imported by the OUT transaction block and its bench.
package usb_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010
  } pid_t;

  localparam logic [3:0] ENDP_ADDR = 4'd4;
  localparam logic [3:0] ENDP_DATA = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_TOKEN,
    ST_SEND_DATA,
    ST_WAIT_HS,
    ST_DONE_OK,
    ST_DONE_FAIL
  } out_state_t;

endpackage

// File: rtl/out_transaction_fsm_if.sv
// Bus bundle between sequencer, OUT transaction FSM and packet codec.
// slave: FSM view (sequencer/codec inputs, request/result outputs).
interface out_transaction_fsm_if;

  logic        out_trans_start;
  logic [3:0]  out_endp;
  logic [63:0] out_data;
  logic        out_trans_done;
  logic        out_trans_success;
  logic        out_trans_failure;
  logic        pkt_send;
  logic [3:0]  pkt_pid;
  logic [6:0]  pkt_addr;
  logic [3:0]  pkt_endp;
  logic [63:0] pkt_payload;
  logic        pkt_sent;
  logic        rx_valid;
  logic [3:0]  rx_pid;
  logic        rx_error;

  modport slave (
    input  out_trans_start,
    input  out_endp,
    input  out_data,
    output out_trans_done,
    output out_trans_success,
    output out_trans_failure,
    output pkt_send,
    output pkt_pid,
    output pkt_addr,
    output pkt_endp,
    output pkt_payload,
    input  pkt_sent,
    input  rx_valid,
    input  rx_pid,
    input  rx_error
  );

  modport master (
    output out_trans_start,
    output out_endp,
    output out_data,
    input  out_trans_done,
    input  out_trans_success,
    input  out_trans_failure,
    input  pkt_send,
    input  pkt_pid,
    input  pkt_addr,
    input  pkt_endp,
    input  pkt_payload,
    output pkt_sent,
    output rx_valid,
    output rx_pid,
    output rx_error
  );

endinterface

// File: rtl/usb_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Ports: clock, reset (async high), clear, en in; q out (W bits).
module usb_counter #(
  parameter int W   = 4,
  parameter int MAX = (1 << W) - 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAXV = W'(MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (en && q != MAXV) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/out_transaction_fsm.sv
// USB OUT transaction: OUT token, DATA0, handshake wait with retries.
// Ports: clock, reset (async high); bus (slave) carries sequencer+codec.
module out_transaction_fsm
  import usb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR       = 7'd5,
  parameter int         MAX_RETRIES    = 8,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input logic                  clock,
  input logic                  reset,
  out_transaction_fsm_if.slave bus
);

  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RW-1:0] LAST_TRY = RW'(MAX_RETRIES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  out_state_t state;
  out_state_t nxt;

  logic [RW-1:0] retry_q;
  logic [TW-1:0] timer_q;
  logic [3:0]    endp_q;
  logic [63:0]   data_q;

  logic start_acc;
  logic send_done;
  logic rx_ack;
  logic timeout;
  logic attempt_fail;

  logic          send_d;
  logic [3:0]    pid_d;
  logic [6:0]    addr_d;
  logic [3:0]    endp_d;
  logic [3:0]    endp_n;
  logic [63:0]   payload_d;
  logic          done_d;
  logic          ok_d;
  logic          fail_d;

  assign start_acc = (state == ST_IDLE) && bus.out_trans_start;
  // A pkt_sent only completes a packet we are actually requesting.
  assign send_done = bus.pkt_sent && bus.pkt_send;
  assign rx_ack = bus.rx_valid && !bus.rx_error &&
                  (bus.rx_pid == PID_ACK);
  // Timeout fires on the cycle the timer would reach its limit,
  // and only without a reply, so a same-cycle reply wins.
  assign timeout = !bus.rx_valid && (timer_q >= TMO_LAST);
  assign attempt_fail = (state == ST_WAIT_HS) && !rx_ack &&
                        (bus.rx_valid || timeout);
  assign endp_n = start_acc ? bus.out_endp : endp_q;

  usb_counter #(
    .W   (RW),
    .MAX (MAX_RETRIES)
  ) u_retry (
    .clock (clock),
    .reset (reset),
    .clear (start_acc),
    .en    (attempt_fail),
    .q     (retry_q)
  );

  usb_counter #(
    .W   (TW),
    .MAX (TIMEOUT_CYCLES)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .clear ((state == ST_SEND_DATA) && send_done),
    .en    ((state == ST_WAIT_HS) && !bus.rx_valid),
    .q     (timer_q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (bus.out_trans_start) nxt = ST_SEND_TOKEN;
      end
      ST_SEND_TOKEN: begin
        if (send_done) nxt = ST_SEND_DATA;
      end
      ST_SEND_DATA: begin
        if (send_done) nxt = ST_WAIT_HS;
      end
      ST_WAIT_HS: begin
        if (rx_ack) begin
          nxt = ST_DONE_OK;
        end else if (attempt_fail) begin
          nxt = (retry_q == LAST_TRY) ? ST_DONE_FAIL
                                      : ST_SEND_DATA;
        end
      end
      ST_DONE_OK:   nxt = ST_IDLE;
      ST_DONE_FAIL: nxt = ST_IDLE;
      default:      nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they
  // line up with the state they describe. pkt_send drops for one
  // cycle after each completed packet.
  always_comb begin
    send_d    = 1'b0;
    pid_d     = '0;
    addr_d    = '0;
    endp_d    = '0;
    payload_d = '0;
    done_d    = 1'b0;
    ok_d      = 1'b0;
    fail_d    = 1'b0;
    unique case (1'b1)
      nxt == ST_SEND_TOKEN: begin
        send_d = 1'b1;
        pid_d  = PID_OUT;
        addr_d = DEV_ADDR;
        endp_d = endp_n;
      end
      nxt == ST_SEND_DATA: begin
        send_d    = !send_done;
        pid_d     = PID_DATA0;
        payload_d = data_q;
      end
      nxt == ST_DONE_OK: begin
        done_d = 1'b1;
        ok_d   = 1'b1;
      end
      nxt == ST_DONE_FAIL: begin
        done_d = 1'b1;
        fail_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      endp_q <= '0;
      data_q <= '0;
    end else if (start_acc) begin
      endp_q <= bus.out_endp;
      data_q <= bus.out_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.pkt_send          <= 1'b0;
      bus.pkt_pid           <= '0;
      bus.pkt_addr          <= '0;
      bus.pkt_endp          <= '0;
      bus.pkt_payload       <= '0;
      bus.out_trans_done    <= 1'b0;
      bus.out_trans_success <= 1'b0;
      bus.out_trans_failure <= 1'b0;
    end else begin
      bus.pkt_send          <= send_d;
      bus.pkt_pid           <= pid_d;
      bus.pkt_addr          <= addr_d;
      bus.pkt_endp          <= endp_d;
      bus.pkt_payload       <= payload_d;
      bus.out_trans_done    <= done_d;
      bus.out_trans_success <= ok_d;
      bus.out_trans_failure <= fail_d;
    end
  end

endmodule
